// File: rtl/t03_nes_reader.sv
// Purpose : autonomous NES gamepad poller; publishes the 8 button bits as one atomic 32-bit word.
// Latency : one frame is LATCH_CYCLES + 15*HALF_CYCLES + 1 clk; NES_din updates on the edge leaving DONE.
// Backpr. : none; the CPU samples NES_din/NES_ack whenever it likes and always sees a whole frame.
//
// Ports:
//   clk        system clock
//   rst        asynchronous active-low reset
//   nes_data   serial pad data, asynchronous, active-low (0 = pressed)
//   nes_latch  pad latch strobe
//   nes_pulse  pad clock strobe
//   NES_din    {24'b0, A,B,Select,Start,Up,Down,Left,Right}, 1 = pressed
//   NES_ack    set after the first complete frame since reset, sticky
module t03_nes_reader #(
  parameter int LATCH_CYCLES = 120,
  parameter int HALF_CYCLES  = 60,
  parameter int POLL_CYCLES  = 166667
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        nes_data,
  output logic        nes_latch,
  output logic        nes_pulse,
  output logic [31:0] NES_din,
  output logic        NES_ack
);

  localparam int PW = $clog2(POLL_CYCLES);
  localparam int TW = $clog2((LATCH_CYCLES > HALF_CYCLES) ? LATCH_CYCLES : HALF_CYCLES);

  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_CYCLES - 1);
  localparam logic [TW-1:0] LATCH_LD  = TW'(LATCH_CYCLES - 1);
  localparam logic [TW-1:0] HALF_LD   = TW'(HALF_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    GAP,
    PULSE,
    DONE
  } state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] poll_cnt;
  logic          poll_wrap;
  logic [TW-1:0] tmr, tmr_nxt;
  logic [2:0]    cnt, cnt_nxt;
  logic [7:0]    shift_q;
  logic [7:0]    din_q;
  logic          sync1, sync2;
  logic          sample;
  logic          publish;

  assign poll_wrap = (poll_cnt == POLL_LAST);

  // Free-running poll counter; its wrap is the only thing that starts a frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      poll_cnt <= '0;
    end else if (poll_wrap) begin
      poll_cnt <= '0;
    end else begin
      poll_cnt <= poll_cnt + 1'b1;
    end
  end

  // Two-flop synchronizer; resets to the idle (released) level of the pad line.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= nes_data;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      tmr   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      tmr   <= tmr_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Phase timer counts down and is reloaded on every state entry, so each
  // state lasts exactly its programmed number of cycles.
  always_comb begin
    state_nxt = state;
    tmr_nxt   = tmr - 1'b1;
    cnt_nxt   = cnt;
    sample    = 1'b0;
    publish   = 1'b0;
    nes_latch = 1'b0;
    nes_pulse = 1'b0;
    case (state)
      IDLE: begin
        tmr_nxt = '0;
        if (poll_wrap) begin
          state_nxt = LATCH;
          tmr_nxt   = LATCH_LD;
        end
      end
      LATCH: begin
        nes_latch = 1'b1;
        if (tmr == '0) begin
          state_nxt = GAP;
          tmr_nxt   = HALF_LD;
          cnt_nxt   = 3'd0;
        end
      end
      GAP: begin
        if (tmr == '0) begin
          sample = 1'b1;
          if (cnt == 3'd7) begin
            state_nxt = DONE;
            tmr_nxt   = '0;
          end else begin
            state_nxt = PULSE;
            tmr_nxt   = HALF_LD;
          end
        end
      end
      PULSE: begin
        nes_pulse = 1'b1;
        if (tmr == '0) begin
          state_nxt = GAP;
          tmr_nxt   = HALF_LD;
          cnt_nxt   = cnt + 3'd1;
        end
      end
      DONE: begin
        publish   = 1'b1;
        state_nxt = IDLE;
        tmr_nxt   = '0;
      end
      default: begin
        state_nxt = IDLE;
        tmr_nxt   = '0;
      end
    endcase
  end

  // Shift register holds pressed=1; A arrives first and ends up in bit 7.
  // The published word is a separate register so the CPU never sees a
  // partially shifted frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_q <= '0;
      din_q   <= '0;
      NES_ack <= 1'b0;
    end else begin
      if (sample) begin
        shift_q <= {shift_q[6:0], ~sync2};
      end
      if (publish) begin
        din_q   <= shift_q;
        NES_ack <= 1'b1;
      end
    end
  end

  assign NES_din = {24'b0, din_q};

endmodule

// File: tb/tb_t03_nes_reader.sv
// Purpose : directed bench for t03_nes_reader with a behavioural NES pad model.
// Latency : frames checked cycle by cycle relative to the latch rising edge.
// Backpr. : n/a.
module tb_t03_nes_reader;

  logic        clk;
  logic        rst;
  logic        nes_data;
  logic        nes_latch;
  logic        nes_pulse;
  logic [31:0] NES_din;
  logic        NES_ack;

  logic [7:0]  btn;
  logic        unplug;
  logic [7:0]  pad_sr;
  logic        pulse_d;

  int checks = 0;
  int errors = 0;

  t03_nes_reader #(
    .LATCH_CYCLES(4),
    .HALF_CYCLES (4),
    .POLL_CYCLES (100)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .nes_data (nes_data),
    .nes_latch(nes_latch),
    .nes_pulse(nes_pulse),
    .NES_din  (NES_din),
    .NES_ack  (NES_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pad: parallel load while latch is high, shift on pulse rise, active-low output.
  initial begin
    pad_sr  = 8'h00;
    pulse_d = 1'b0;
  end
  always @(posedge clk) begin
    if (nes_latch) begin
      pad_sr <= btn;
    end else if (nes_pulse && !pulse_d) begin
      pad_sr <= {pad_sr[6:0], 1'b0};
    end
    pulse_d <= nes_pulse;
  end
  assign nes_data = unplug ? 1'b1 : ~pad_sr[7];

  typedef struct {
    logic        unplug;
    logic [7:0]  btn;
    logic [31:0] exp_din;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Returns the number of falling edges stepped until nes_latch is seen high.
  task automatic wait_latch(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!nes_latch && n < 1000);
  endtask

  // Called at the negedge where latch is first seen high (offset 0).
  task automatic collect(input logic [31:0] old_din, input logic old_ack, input logic [31:0] exp_din);
    int   bad_latch = 0;
    int   bad_pulse = 0;
    int   overlap   = 0;
    int   unstable  = 0;
    int   late_bad  = 0;
    logic exp_p;
    logic exp_l;
    for (int off = 0; off < 70; off++) begin
      if (off > 0) @(negedge clk);
      exp_l = (off < 4);
      exp_p = (off >= 8 && off < 64 && ((off - 8) % 8) < 4);
      if (nes_latch !== exp_l) bad_latch++;
      if (nes_pulse !== exp_p) bad_pulse++;
      if (nes_latch && nes_pulse) overlap++;
      if (off <= 64) begin
        if (NES_din !== old_din || NES_ack !== old_ack) unstable++;
      end else begin
        if (NES_din !== exp_din || NES_ack !== 1'b1) late_bad++;
      end
    end
    check("latch_shape", bad_latch, 0);
    check("pulse_shape", bad_pulse, 0);
    check("strobe_overlap", overlap, 0);
    check("din_hold_before_done", unstable, 0);
    check("din_after_done", late_bad, 0);
    check("din_value", NES_din, exp_din);
    check("ack_value", NES_ack, 1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int          n;
    logic [31:0] old_din;
    logic        old_ack;

    vecs[0] = '{unplug: 1'b1, btn: 8'h55, exp_din: 32'h0000_0000};
    vecs[1] = '{unplug: 1'b0, btn: 8'h90, exp_din: 32'h0000_0090};
    vecs[2] = '{unplug: 1'b0, btn: 8'hFF, exp_din: 32'h0000_00FF};
    vecs[3] = '{unplug: 1'b0, btn: 8'h00, exp_din: 32'h0000_0000};
    vecs[4] = '{unplug: 1'b0, btn: 8'h5A, exp_din: 32'h0000_005A};
    vecs[5] = '{unplug: 1'b0, btn: 8'h81, exp_din: 32'h0000_0081};

    rst    = 1'b0;
    btn    = vecs[0].btn;
    unplug = vecs[0].unplug;
    repeat (3) @(negedge clk);
    check("rst_latch", nes_latch, 0);
    check("rst_pulse", nes_pulse, 0);
    check("rst_din", NES_din, 0);
    check("rst_ack", NES_ack, 0);

    rst = 1'b1;
    #1;
    check("release_din", NES_din, 0);
    check("release_ack", NES_ack, 0);
    wait_latch(n);
    check("first_latch_delay", n, 100);

    old_din = 32'h0;
    old_ack = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) begin
        btn    = vecs[i].btn;
        unplug = vecs[i].unplug;
        wait_latch(n);
        check("poll_period", n, 31);
      end
      collect(old_din, old_ack, vecs[i].exp_din);
      old_din = vecs[i].exp_din;
      old_ack = 1'b1;
    end

    // Reset in the middle of the third pulse.
    wait_latch(n);
    check("poll_period", n, 31);
    repeat (25) @(negedge clk);
    check("pulse3_active", nes_pulse, 1);
    check("pre_reset_din", NES_din, 32'h0000_0081);
    rst = 1'b0;
    #1;
    check("midrst_latch", nes_latch, 0);
    check("midrst_pulse", nes_pulse, 0);
    check("midrst_din", NES_din, 0);
    check("midrst_ack", NES_ack, 0);
    repeat (3) @(negedge clk);
    btn    = 8'h3C;
    unplug = 1'b0;
    rst    = 1'b1;
    #1;
    check("rerelease_din", NES_din, 0);
    check("rerelease_ack", NES_ack, 0);
    wait_latch(n);
    check("latch_after_midrst", n, 100);
    collect(32'h0, 1'b0, 32'h0000_003C);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
